// File: rtl/text_pkg.sv
// Shared constants and stage bundles for the text-mode pixel pipeline.
// 640x480 active area, 80x30 cells of 8x16 glyphs, 12-bit RGB output.
package text_pkg;

    localparam int CHAR_W       = 8;
    localparam int CHAR_H       = 16;
    localparam int TEXT_ADDR_W  = 12;
    localparam int FONT_ADDR_W  = 11;
    localparam int RGB_W        = 12;
    localparam int BLINK_FRAMES = 32;
    localparam int BLINK_W      = $clog2(BLINK_FRAMES);

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [8:0] V_ACTIVE = 9'd480;
    localparam logic [6:0] COLS     = 7'd80;
    localparam logic [4:0] ROWS     = 5'd30;

    localparam logic [3:0] CURSOR_FIRST_LINE = 4'd14;

    localparam logic [BLINK_W-1:0] BLINK_LAST =
        BLINK_W'(BLINK_FRAMES - 1);

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t FG_RGB = 12'hFFF;
    localparam rgb_t BG_RGB = 12'h000;

    // Sideband carried from the position stage to the glyph fetch.
    typedef struct packed {
        logic [2:0] dot_lo;
        logic [3:0] scan_lo;
        logic       in_range;
        logic       frame;
        logic       cur;
    } st1_t;

    // Sideband carried from the glyph fetch to the pixel stage.
    typedef struct packed {
        logic [2:0] dot_lo;
        logic       in_range;
        logic       frame;
        logic       cur;
        logic       inv;
    } st2_t;

    // row*80+col as two shifts and adds.
    function automatic logic [TEXT_ADDR_W-1:0] cell_addr(
        input logic [6:0] col,
        input logic [4:0] row
    );
        logic [TEXT_ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/text_pixel_pipe_if.sv
// Read bus to the external text RAM and font ROM.
// master: pipeline (drives addresses); slave: memories (drive data).
interface text_pixel_pipe_if;
    import text_pkg::*;

    logic [TEXT_ADDR_W-1:0] text_addr;
    logic [7:0]             text_data;
    logic [FONT_ADDR_W-1:0] font_addr;
    logic [7:0]             font_data;

    modport master (
        output text_addr,
        output font_addr,
        input  text_data,
        input  font_data
    );

    modport slave (
        input  text_addr,
        input  font_addr,
        output text_data,
        output font_data
    );

endinterface

// File: rtl/cursor_blink.sv
// Cursor cell register with range-checked writes, plus the frame blink timer.
// Ports: clk, rst_n, frame, wr_en/wr_col/wr_row in; cur_col/cur_row/blink_vis out.
module cursor_blink
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic       wr_en,
    input  logic [6:0] wr_col,
    input  logic [4:0] wr_row,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row,
    output logic       blink_vis
);

    logic [BLINK_W-1:0] cnt;
    logic               phase;
    logic               wrap;
    logic               wr_ok;

    assign wrap  = frame && (cnt == BLINK_LAST);
    assign wr_ok = wr_en && (wr_col < COLS) && (wr_row < ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_col <= '0;
            cur_row <= '0;
            cnt     <= '0;
            phase   <= 1'b1;
        end else begin
            if (wr_ok) begin
                cur_col <= wr_col;
                cur_row <= wr_row;
            end
            if (wrap) begin
                cnt   <= '0;
                phase <= ~phase;
            end else if (frame) begin
                cnt <= cnt + BLINK_W'(1);
            end
        end
    end

    // The sample carrying the frame flag already sees the new phase, so
    // a toggle lands exactly on pixel (0,0) and never mid-frame.
    assign blink_vis = wrap ? ~phase : phase;

endmodule

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel generator: position -> text RAM -> font ROM -> RGB, 5-cycle latency.
// Ports: clk, rst_n, dot/scanline counters, cursor controls, mem bus, pixel_rgb/valid, frame_start.
module text_pixel_pipe
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] dot_counter,
    input  logic [8:0] scanline_counter,
    input  logic       cursor_we,
    input  logic [6:0] cursor_col,
    input  logic [4:0] cursor_row,
    input  logic       cursor_en,
    text_pixel_pipe_if.master mem,
    output rgb_t       pixel_rgb,
    output logic       pixel_valid,
    output logic       frame_start
);

    logic [6:0] col;
    logic [4:0] row;
    logic       in_range;
    logic       frame;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       blink_vis;
    logic       pix_on;

    st1_t s1_d, s1, s1d;
    st2_t s2_d, s2, s2d;

    assign col      = dot_counter[9:3];
    assign row      = scanline_counter[8:4];
    assign in_range = (dot_counter < H_ACTIVE) &&
                      (scanline_counter < V_ACTIVE);
    assign frame    = (dot_counter == '0) && (scanline_counter == '0);

    cursor_blink u_cursor (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame     (frame),
        .wr_en     (cursor_we),
        .wr_col    (cursor_col),
        .wr_row    (cursor_row),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .blink_vis (blink_vis)
    );

    always_comb begin
        s1_d          = '0;
        s1_d.dot_lo   = dot_counter[2:0];
        s1_d.scan_lo  = scanline_counter[3:0];
        s1_d.in_range = in_range;
        s1_d.frame    = frame;
        s1_d.cur      = (col == cur_col) && (row == cur_row) &&
                        (scanline_counter[3:0] >= CURSOR_FIRST_LINE) &&
                        blink_vis;
    end

    always_comb begin
        s2_d          = '0;
        s2_d.dot_lo   = s1d.dot_lo;
        s2_d.in_range = s1d.in_range;
        s2_d.frame    = s1d.frame;
        s2_d.cur      = s1d.cur;
        s2_d.inv      = mem.text_data[7];
    end

    // Bit 7 of the glyph row is the leftmost dot, hence the inverted index.
    assign pix_on = mem.font_data[~s2d.dot_lo] ^ s2d.inv ^
                    (s2d.cur & cursor_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.text_addr <= '0;
            mem.font_addr <= '0;
            s1            <= '0;
            s1d           <= '0;
            s2            <= '0;
            s2d           <= '0;
            pixel_rgb     <= BG_RGB;
            pixel_valid   <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            mem.text_addr <= in_range ? cell_addr(col, row) : '0;
            s1            <= s1_d;
            s1d           <= s1;
            mem.font_addr <= {mem.text_data[6:0], s1d.scan_lo};
            s2            <= s2_d;
            s2d           <= s2;
            pixel_rgb     <= (s2d.in_range && pix_on) ? FG_RGB : BG_RGB;
            pixel_valid   <= s2d.in_range;
            frame_start   <= s2d.frame;
        end
    end

endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Text-mode pixel generator, directly downstream of the dot/scanline counter block.
- Maps each (dot, scanline) position on the 640x480 active area to a character cell of the 80x30, 8x16-font text screen.
- Fetches the character code from the external synchronous text RAM, then the glyph row from the external synchronous font ROM.
- Outputs one 12-bit RGB pixel per clock; overlays a blinking underline cursor.

Parameters:
- H_ACTIVE, 640, active dots per line
- V_ACTIVE, 480, active scanlines per frame
- COLS, 80, character columns (H_ACTIVE/8)
- ROWS, 30, character rows (V_ACTIVE/16)
- BLINK_FRAMES, 32, frames per cursor blink half-period
- FG_RGB, 12'hFFF, foreground colour
- BG_RGB, 12'h000, background colour

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dot_counter  in  10  current x position, from counter block
- scanline_counter  in  9  current y position, from counter block
- cursor_we  in  1  cursor position write strobe
- cursor_col  in  7  cursor column, sampled on cursor_we
- cursor_row  in  5  cursor row, sampled on cursor_we
- cursor_en  in  1  cursor display enable (level)
- text_addr  out  12  text RAM read address, row*80+col
- text_data  in  8  text RAM read data, valid one cycle after text_addr; [7]=inverse, [6:0]=char code
- font_addr  out  11  font ROM read address, {char[6:0], glyph_row[3:0]}
- font_data  in  8  font ROM row, valid one cycle after font_addr; bit 7 = leftmost pixel
- pixel_rgb  out  12  output pixel
- pixel_valid  out  1  pixel_rgb corresponds to an in-range input position
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async, rst_n=0): every pipeline register clears.
  - text_addr=0, font_addr=0, pixel_rgb=BG_RGB, pixel_valid=0, frame_start=0.
  - Cursor position (0,0); blink frame count 0; blink phase 1 (visible).
- Stage 1 (register, edge after input cycle t):
  - col=dot[9:3], row=scan[8:4].
  - text_addr = (row<<6)+(row<<4)+col; no multiplier. Max 2399, fits 12 bits.
  - Pipelined alongside: dot[2:0], scan[3:0], in_range, frame flag.
  - in_range = (dot<H_ACTIVE)&&(scan<V_ACTIVE).
  - cursor_hit = (col==cur_col)&&(row==cur_row)&&(scan[3:0]>=14).
- Stage 2 (t+2): text_data valid. font_addr registered as {text_data[6:0], scan_lo}; inverse bit and sideband pipelined.
- Stage 3 (t+4): font_data valid. Registered on the same edge:
  - bit = font_data[7-dot_lo] ^ inverse ^ (cursor_hit & cursor_en & blink_phase).
  - pixel_rgb = bit ? FG_RGB : BG_RGB.
  - pixel_valid = in_range.
- Total latency: counters at cycle t produce pixel_rgb valid at cycle t+5; throughput 1 pixel/clock, no stalls.
- Out-of-range input: pixel_valid=0, pixel_rgb=BG_RGB. text_addr is still issued and clamped to 0.
- After reset, pixel_valid stays 0 until the first in-range sample reaches the output (5 cycles).
- Frame flag: dot==0 && scan==0 at input; frame_start pulses 5 cycles later.
- Blink: on each input frame flag, frame count increments.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Phase changes take effect from pixel (0,0) onward, never mid-frame.
- Cursor write: on cursor_we, the position is loaded only if cursor_col<COLS && cursor_row<ROWS; otherwise the write is ignored and the old position is held.
  - A new position applies to the stage-1 compare in the cycle after the write.
  - A write coinciding with the frame flag is still accepted.
- cursor_en=0: no cursor overlay. Blink counting continues.

Decomposition:
- Package text_pkg: CHAR_W=8, CHAR_H=16, COLS, ROWS, TEXT_ADDR_W=12, FONT_ADDR_W=11, RGB_W=12, CURSOR_FIRST_LINE=14, typedef rgb_t.
- Sub-module cursor_blink: cursor position register, write validation, frame counter, blink_phase.
- Address/pixel pipeline stays in text_pixel_pipe.

Test Plan:
- Reset then (dot,scan)=(0,0) -> text_addr=0 at t+1; pixel_valid=0 before t+5, 1 at t+5.
- (dot,scan)=(639,479) -> text_addr=2399; font_addr={char,4'hF}. With font_data=8'h01: pixel_rgb=FG_RGB (bit 0 selected for dot_lo=7).
- text_data=8'hC1 (inverse 'A'), font_data=8'h00 -> pixel_rgb=FG_RGB; text_data=8'h41 with same font_data -> BG_RGB.
- cursor_we with col=5,row=2, cursor_en=1, font_data=0 -> pixels for dot 40..47 on scan 46..47 = FG_RGB; scan 45 = BG_RGB.
- cursor_we with col=80 -> ignored; the cursor remains at its previous cell.
- Run 32 frames (shortened timing) -> blink_phase toggles exactly at frame_start of frame 32; cursor pixels go BG. Assert rst_n mid-frame -> outputs reset immediately, blink phase returns to 1.
- (dot,scan)=(700,10) -> pixel_valid=0, pixel_rgb=BG_RGB at t+5.
